// File: rtl/tex_index_pipe_pkg.sv
// Shared texture-path definitions: pixel format codes and the per-lane texel result.
package tex_index_pipe_pkg;

  typedef enum logic [1:0] {
    PIX_4BIT     = 2'd0,
    PIX_8BIT     = 2'd1,
    PIX_16BIT    = 2'd2,
    PIX_RESERVED = 2'd3
  } tex_fmt_e;

  typedef struct packed {
    logic [7:0]  index;
    logic [15:0] color16;
  } texel_t;

  // Reserved format is decoded exactly like 16-bit direct colour.
  function automatic logic is_direct(input tex_fmt_e fmt);
    return (fmt == PIX_16BIT) || (fmt == PIX_RESERVED);
  endfunction

endpackage

// File: rtl/tex_index_pipe_if.sv
// Beat-level bus of tex_index_pipe; TEX_IDX_STATS_EN adds the statistics signals.
interface tex_index_pipe_if #(
  parameter int unsigned NUM_LANES = 2,
  parameter int unsigned IDX_W     = 8
);
  logic                       i_fmtLoad;
  logic [1:0]                 i_texFormat;
  logic                       i_valid;
  logic                       o_ready;
  logic [NUM_LANES*16-1:0]    i_data;
  logic [NUM_LANES*2-1:0]     i_uLSB;
  logic [NUM_LANES-1:0]       i_laneMask;
  logic                       o_valid;
  logic                       i_ready;
  logic [NUM_LANES*IDX_W-1:0] o_index;
  logic [NUM_LANES*16-1:0]    o_color16;
  logic                       o_isDirect;
  logic [NUM_LANES-1:0]       o_laneMask;
  logic                       o_fmtErr;
  logic                       o_busy;
`ifdef TEX_IDX_STATS_EN
  logic [31:0]                o_statBeats;
  logic [31:0]                o_statStall;
  logic                       i_statClr;
`endif

  modport slave (
    input  i_fmtLoad, i_texFormat, i_valid, i_data, i_uLSB, i_laneMask, i_ready,
`ifdef TEX_IDX_STATS_EN
    input  i_statClr,
    output o_statBeats, o_statStall,
`endif
    output o_ready, o_valid, o_index, o_color16, o_isDirect, o_laneMask, o_fmtErr, o_busy
  );

  modport master (
    output i_fmtLoad, i_texFormat, i_valid, i_data, i_uLSB, i_laneMask, i_ready,
`ifdef TEX_IDX_STATS_EN
    output i_statClr,
    input  o_statBeats, o_statStall,
`endif
    input  o_ready, o_valid, o_index, o_color16, o_isDirect, o_laneMask, o_fmtErr, o_busy
  );

endinterface

// File: rtl/tex_lane_extract.sv
// Combinational single-lane texel decoder: CLUT index for 4/8-bit, raw word for direct modes.
module tex_lane_extract
  import tex_index_pipe_pkg::*;
(
  input  logic [15:0] word,
  input  logic [1:0]  ulsb,
  input  tex_fmt_e    fmt,
  input  logic        active,
  output texel_t      texel
);

  always_comb begin
    texel = '0;
    if (active) begin
      case (fmt)
        PIX_4BIT: texel.index = {4'd0, word[{ulsb, 2'b00} +: 4]};
        PIX_8BIT: texel.index = ulsb[0] ? word[15:8] : word[7:0];
        default:  texel.color16 = word;
      endcase
    end
  end

endmodule

// File: rtl/tex_index_pipe.sv
// Multi-lane two-stage texel index extractor with valid/ready flow control.
// Optional TEX_IDX_STATS_EN adds saturating accepted-beat and stall counters.
module tex_index_pipe
  import tex_index_pipe_pkg::*;
#(
  parameter int unsigned NUM_LANES = 2,
  parameter int unsigned IDX_W     = 8
) (
  input  logic            clk,
  input  logic            i_nrst,
  tex_index_pipe_if.slave bus
);

  tex_fmt_e                 fmt_q;
  texel_t [NUM_LANES-1:0]   lane_res;
  texel_t [NUM_LANES-1:0]   s1_res;
  texel_t [NUM_LANES-1:0]   s2_res;
  logic [NUM_LANES-1:0]     s1_mask;
  logic [NUM_LANES-1:0]     s2_mask;
  logic                     s1_valid;
  logic                     s2_valid;
  logic                     s1_direct;
  logic                     s2_direct;
  logic                     fmt_err;
  logic                     s2_load;
  logic                     in_ready;
  logic                     accept;

  // S1 may take a new beat in the same cycle it hands its current one to S2.
  assign s2_load  = !s2_valid || bus.i_ready;
  assign in_ready = !s1_valid || s2_load;
  assign accept   = bus.i_valid && in_ready;

  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    tex_lane_extract u_extract (
      .word   (bus.i_data[16*k +: 16]),
      .ulsb   (bus.i_uLSB[2*k +: 2]),
      .fmt    (fmt_q),
      .active (bus.i_laneMask[k]),
      .texel  (lane_res[k])
    );

    assign bus.o_index[IDX_W*k +: IDX_W] = IDX_W'(s2_res[k].index);
    assign bus.o_color16[16*k +: 16]     = s2_res[k].color16;
  end

  // Beats decode with fmt_q as it stood on their acceptance edge, so a
  // coincident load only affects the following beat.
  always_ff @(posedge clk) begin
    if (!i_nrst) begin
      fmt_q     <= PIX_4BIT;
      s1_valid  <= 1'b0;
      s2_valid  <= 1'b0;
      s1_res    <= '0;
      s2_res    <= '0;
      s1_mask   <= '0;
      s2_mask   <= '0;
      s1_direct <= 1'b0;
      s2_direct <= 1'b0;
      fmt_err   <= 1'b0;
    end else begin
      if (bus.i_fmtLoad) fmt_q <= tex_fmt_e'(bus.i_texFormat);
      if (in_ready) s1_valid <= bus.i_valid;
      if (accept) begin
        s1_res    <= lane_res;
        s1_mask   <= bus.i_laneMask;
        s1_direct <= is_direct(fmt_q);
        if (fmt_q == PIX_RESERVED) fmt_err <= 1'b1;
      end
      if (s2_load) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          s2_res    <= s1_res;
          s2_mask   <= s1_mask;
          s2_direct <= s1_direct;
        end
      end
    end
  end

  assign bus.o_ready    = in_ready;
  assign bus.o_valid    = s2_valid;
  assign bus.o_isDirect = s2_direct;
  assign bus.o_laneMask = s2_mask;
  assign bus.o_fmtErr   = fmt_err;
  assign bus.o_busy     = s1_valid || s2_valid;

`ifdef TEX_IDX_STATS_EN
  logic [31:0] stat_beats;
  logic [31:0] stat_stall;

  always_ff @(posedge clk) begin
    if (!i_nrst || bus.i_statClr) begin
      stat_beats <= '0;
      stat_stall <= '0;
    end else begin
      if (accept && stat_beats != '1) stat_beats <= stat_beats + 32'd1;
      if (s2_valid && !bus.i_ready && stat_stall != '1) stat_stall <= stat_stall + 32'd1;
    end
  end

  assign bus.o_statBeats = stat_beats;
  assign bus.o_statStall = stat_stall;
`endif

endmodule

// File: tb/tb_tex_index_pipe.sv
// Directed bench for tex_index_pipe: decode modes, masking, backpressure, format timing, reset.
module tb_tex_index_pipe;
  import tex_index_pipe_pkg::*;

  localparam int unsigned NL = 2;

  logic clk  = 1'b0;
  logic nrst = 1'b0;
  always #5 clk = ~clk;

  tex_index_pipe_if #(.NUM_LANES(NL), .IDX_W(8)) tif ();

  tex_index_pipe #(.NUM_LANES(NL), .IDX_W(8)) dut (
    .clk    (clk),
    .i_nrst (nrst),
    .bus    (tif)
  );

  typedef struct {
    logic [15:0] idx;
    logic [31:0] col;
    logic        direct;
    logic [1:0]  mask;
    logic        chk_lat;
  } exp_t;

  exp_t exp_q[$];
  int   acc_q[$];
  int   cyc      = 0;
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, want, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: compares every valid output cycle against the expectation queue head.
  always @(negedge clk) begin : monitor
    exp_t  e;
    string pre;
    if (!nrst) begin
      exp_q.delete();
      acc_q.delete();
    end else begin
      if (tif.i_valid && tif.o_ready) acc_q.push_back(cyc);
      if (tif.o_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", 32'd1, 32'd0);
        end else begin
          e   = exp_q[0];
          pre = tif.i_ready ? "out" : "hold";
          check({pre, "_index"},  32'(tif.o_index),    32'(e.idx));
          check({pre, "_color"},  32'(tif.o_color16),  e.col);
          check({pre, "_direct"}, 32'(tif.o_isDirect), 32'(e.direct));
          check({pre, "_mask"},   32'(tif.o_laneMask), 32'(e.mask));
          if (tif.i_ready) begin
            if (e.chk_lat && acc_q.size() > 0) check("latency", 32'(cyc - acc_q[0]), 32'd2);
            void'(exp_q.pop_front());
            if (acc_q.size() > 0) void'(acc_q.pop_front());
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_fmt(input logic [1:0] f);
    tif.i_fmtLoad   = 1'b1;
    tif.i_texFormat = f;
    tick();
    tif.i_fmtLoad   = 1'b0;
  endtask

  task automatic send(input logic [15:0] w0, input logic [15:0] w1,
                      input logic [1:0] u0, input logic [1:0] u1, input logic [1:0] m,
                      input logic [7:0] e0, input logic [7:0] e1,
                      input logic [15:0] c0, input logic [15:0] c1,
                      input logic dir, input logic lat,
                      input logic ld = 1'b0, input logic [1:0] ldf = 2'd0);
    bit ok = 1'b0;
    exp_q.push_back('{idx: {e1, e0}, col: {c1, c0}, direct: dir, mask: m, chk_lat: lat});
    tif.i_valid     = 1'b1;
    tif.i_data      = {w1, w0};
    tif.i_uLSB      = {u1, u0};
    tif.i_laneMask  = m;
    tif.i_fmtLoad   = ld;
    tif.i_texFormat = ldf;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (tif.o_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("accept_timeout", 32'd0, 32'd1);
    tick();
    tif.i_valid   = 1'b0;
    tif.i_fmtLoad = 1'b0;
  endtask

  task automatic drain();
    for (int t = 0; t < 50; t++) begin
      if (exp_q.size() == 0) break;
      tick();
    end
    check("drain_empty", 32'(exp_q.size()), 32'd0);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    tif.i_fmtLoad   = 1'b0;
    tif.i_texFormat = 2'd0;
    tif.i_valid     = 1'b0;
    tif.i_data      = '0;
    tif.i_uLSB      = '0;
    tif.i_laneMask  = '0;
    tif.i_ready     = 1'b1;
`ifdef TEX_IDX_STATS_EN
    tif.i_statClr   = 1'b0;
`endif
    nrst = 1'b0;
    repeat (2) tick();
    check("rst_valid",  32'(tif.o_valid),    32'd0);
    check("rst_busy",   32'(tif.o_busy),     32'd0);
    check("rst_fmterr", 32'(tif.o_fmtErr),   32'd0);
    check("rst_index",  32'(tif.o_index),    32'd0);
    check("rst_color",  tif.o_color16,       32'd0);
    check("rst_direct", 32'(tif.o_isDirect), 32'd0);
    check("rst_mask",   32'(tif.o_laneMask), 32'd0);
    nrst = 1'b1;
    tick();
    check("idle_ready", 32'(tif.o_ready), 32'd1);

    // 4-bit mode (reset default); lane1 word 0x1234 walks nibbles in reverse
    send(16'hA5C3, 16'h1234, 2'd0, 2'd3, 2'b11, 8'h03, 8'h01, 16'h0, 16'h0, 1'b0, 1'b1);
    send(16'hA5C3, 16'h1234, 2'd1, 2'd2, 2'b11, 8'h0C, 8'h02, 16'h0, 16'h0, 1'b0, 1'b1);
    send(16'hA5C3, 16'h1234, 2'd2, 2'd1, 2'b11, 8'h05, 8'h03, 16'h0, 16'h0, 1'b0, 1'b1);
    send(16'hA5C3, 16'h1234, 2'd3, 2'd0, 2'b11, 8'h0A, 8'h04, 16'h0, 16'h0, 1'b0, 1'b1);
    drain();

    // 8-bit mode: only uLSB[0] selects the byte
    set_fmt(2'd1);
    send(16'h7F12, 16'hBEEF, 2'd0, 2'd2, 2'b11, 8'h12, 8'hEF, 16'h0, 16'h0, 1'b0, 1'b1);
    send(16'h7F12, 16'hBEEF, 2'd1, 2'd1, 2'b11, 8'h7F, 8'hBE, 16'h0, 16'h0, 1'b0, 1'b1);
    drain();

    // 16-bit direct with lane1 masked, then reserved format
    set_fmt(2'd2);
    send(16'h8421, 16'h5555, 2'd0, 2'd0, 2'b01, 8'h00, 8'h00, 16'h8421, 16'h0000, 1'b1, 1'b1);
    drain();
    check("fmterr_fmt16", 32'(tif.o_fmtErr), 32'd0);
    set_fmt(2'd3);
    send(16'h8421, 16'h5555, 2'd0, 2'd0, 2'b01, 8'h00, 8'h00, 16'h8421, 16'h0000, 1'b1, 1'b1);
    drain();
    check("fmterr_set", 32'(tif.o_fmtErr), 32'd1);

    // 6-beat burst in 8-bit mode with i_ready low for 4 cycles mid-burst
    set_fmt(2'd1);
    check("fmterr_sticky", 32'(tif.o_fmtErr), 32'd1);
    fork
      begin
        for (int k = 0; k < 6; k++) begin
          logic [7:0] kb, lo0, hi0, lo1, hi1;
          kb  = 8'(k);
          lo0 = 8'h30 + kb;
          hi0 = 8'hC0 + kb;
          lo1 = 8'h60 + kb;
          hi1 = 8'h50 + kb;
          send({hi0, lo0}, {hi1, lo1}, {1'b0, kb[0]}, {1'b0, ~kb[0]}, 2'b11,
               kb[0] ? hi0 : lo0, kb[0] ? lo1 : hi1, 16'h0, 16'h0, 1'b0, 1'b0);
        end
      end
      begin
        repeat (3) @(posedge clk);
        #1 tif.i_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("bp_ready_low", 32'(tif.o_ready), 32'd0);
        check("bp_busy",      32'(tif.o_busy),  32'd1);
        repeat (3) @(posedge clk);
        #1 tif.i_ready = 1'b1;
      end
    join
    drain();

    // Format load coincident with acceptance: this beat 4-bit, next beat 8-bit
    set_fmt(2'd0);
    send(16'h7F12, 16'h00F0, 2'd1, 2'd1, 2'b11, 8'h01, 8'h0F, 16'h0, 16'h0, 1'b0, 1'b1, 1'b1, 2'd1);
    send(16'h7F12, 16'h00F0, 2'd1, 2'd1, 2'b11, 8'h7F, 8'h00, 16'h0, 16'h0, 1'b0, 1'b1);
    drain();

    // Reset with two beats parked in the pipeline
    tif.i_ready = 1'b0;
    send(16'h7F12, 16'hBEEF, 2'd0, 2'd2, 2'b11, 8'h12, 8'hEF, 16'h0, 16'h0, 1'b0, 1'b0);
    send(16'h7F12, 16'hBEEF, 2'd1, 2'd1, 2'b11, 8'h7F, 8'hBE, 16'h0, 16'h0, 1'b0, 1'b0);
    check("inflight_busy",  32'(tif.o_busy),  32'd1);
    check("inflight_ready", 32'(tif.o_ready), 32'd0);
    nrst = 1'b0;
    tick();
    check("mid_rst_valid",  32'(tif.o_valid),  32'd0);
    check("mid_rst_busy",   32'(tif.o_busy),   32'd0);
    check("mid_rst_fmterr", 32'(tif.o_fmtErr), 32'd0);
    check("mid_rst_index",  32'(tif.o_index),  32'd0);
    nrst = 1'b1;
    tif.i_ready = 1'b1;
    repeat (5) tick();
    check("post_rst_valid", 32'(tif.o_valid), 32'd0);
    // Format register must be back to 4-bit after reset
    send(16'hA5C3, 16'h1234, 2'd2, 2'd2, 2'b11, 8'h05, 8'h02, 16'h0, 16'h0, 1'b0, 1'b1);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
